// File: rtl/cpu_dump_pkg.sv
// Shared types and constants for the CPU state dump unit.
package cpu_dump_pkg;

    // Dump FSM: header words, then register file, then low data memory.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        REG  = 2'd2,
        MEM  = 2'd3
    } dump_state_t;

    localparam int HDR_WORDS = 4;

    // Position of each frozen value inside the header section.
    localparam int HDR_CYCLE = 0;
    localparam int HDR_STALL = 1;
    localparam int HDR_FLUSH = 2;
    localparam int HDR_PC    = 3;

endpackage

// File: rtl/perf_counter.sv
// Cycle / stall / flush performance counters with a capture strobe that
// freezes the stall and flush counts into header registers.  The cycle
// count is exposed live; the dump unit loads it straight into its output
// register on the capture edge, so that register serves as its header copy.
module perf_counter
    import cpu_dump_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              branch,
    input  logic              flush,
    input  logic              capture,
    output logic [DATA_W-1:0] cycle_cnt,
    output logic [DATA_W-1:0] stall_hdr,
    output logic [DATA_W-1:0] flush_hdr
);

    logic [DATA_W-1:0] stall_cnt;
    logic [DATA_W-1:0] flush_cnt;

    // Free-running gated counters; capture takes the pre-increment values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            stall_hdr <= '0;
            flush_hdr <= '0;
        end else begin
            if (start)                     cycle_cnt <= cycle_cnt + 1'b1;
            if (start && stall && !branch) stall_cnt <= stall_cnt + 1'b1;
            if (start && flush)            flush_cnt <= flush_cnt + 1'b1;
            if (capture) begin
                stall_hdr <= stall_cnt;
                flush_hdr <= flush_cnt;
            end
        end
    end

endmodule

// File: rtl/cpu_state_dump.sv
// Debug readout unit: streams header (cycle, stall, flush, PC), register
// file and low data memory over a valid/ready word interface.
// Optional macro DUMP_DMEM_EN: when defined, the data-memory section is
// appended; when undefined the stream ends at the last register word.
//
// state | meaning
// IDLE  | no snapshot, waiting for snap_i
// HDR   | sending the four frozen header words
// REG   | sending register words x0..x(NUM_REGS-1)
// MEM   | sending data-memory words 0..NUM_DMEM-1
module cpu_state_dump
    import cpu_dump_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_DMEM = 8,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              snap_i,
    output logic [4:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [7:0]        dmem_addr_o,
    input  logic [DATA_W-1:0] dmem_data_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              dout_last_o,
    output logic              busy_o
);

    localparam int IDX_W = 8;
    localparam logic [IDX_W-1:0] LAST_HDR = IDX_W'(HDR_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(NUM_DMEM - 1);

    dump_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_nx;
    logic [DATA_W-1:0] dout_q, hdr_pc_q;
    logic              valid_q, last_q;
    logic [DATA_W-1:0] cycle_cnt, stall_hdr, flush_hdr;
    logic              xfer, capture, load, load_last;
    logic [DATA_W-1:0] load_word;

    assign xfer    = valid_q & dout_ready_i;
    assign capture = (state_q == IDLE) & snap_i;
    assign idx_nx  = idx_q + 1'b1;

    perf_counter #(.DATA_W(DATA_W)) u_perf (
        .clk       (clk_i),
        .rst       (rst_i),
        .start     (start_i),
        .stall     (stall_i),
        .branch    (branch_i),
        .flush     (flush_i),
        .capture   (capture),
        .cycle_cnt (cycle_cnt),
        .stall_hdr (stall_hdr),
        .flush_hdr (flush_hdr)
    );

    // State register with the word index inside the current section.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: sections advance on the handshake of their last word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (snap_i) begin
                state_d = HDR;
                idx_d   = '0;
            end
            HDR: if (xfer) begin
                if (idx_q == LAST_HDR) begin
                    state_d = REG;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_nx;
                end
            end
            REG: if (xfer) begin
                if (idx_q == LAST_REG) begin
`ifdef DUMP_DMEM_EN
                    state_d = MEM;
`else
                    state_d = IDLE;
`endif
                    idx_d   = '0;
                end else begin
                    idx_d = idx_nx;
                end
            end
            MEM: if (xfer) begin
                if (idx_q == LAST_MEM) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_nx;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output logic: read addresses and the word to load at the next transfer.
    always_comb begin
        busy_o      = (state_q != IDLE);
        reg_addr_o  = (state_q == REG) ? idx_nx[4:0] : 5'd0;
        dmem_addr_o = 8'd0;
        load        = 1'b0;
        load_word   = '0;
        load_last   = 1'b0;
`ifdef DUMP_DMEM_EN
        if (state_q == MEM) dmem_addr_o = idx_nx;
`endif
        case (state_q)
            IDLE: begin
                load      = snap_i;
                load_word = cycle_cnt;
            end
            HDR: begin
                load = xfer;
                if (idx_q == IDX_W'(HDR_CYCLE))      load_word = stall_hdr;
                else if (idx_q == IDX_W'(HDR_STALL)) load_word = flush_hdr;
                else if (idx_q == IDX_W'(HDR_FLUSH)) load_word = hdr_pc_q;
                else                                 load_word = reg_data_i;
            end
            REG: begin
                load = xfer & ~last_q;
`ifdef DUMP_DMEM_EN
                if (idx_q == LAST_REG) begin
                    load_word = dmem_data_i;
                    load_last = (NUM_DMEM == 1);
                end else begin
                    load_word = reg_data_i;
                end
`else
                load_word = reg_data_i;
                load_last = (idx_nx == LAST_REG);
`endif
            end
            MEM: begin
                load      = xfer & ~last_q;
                load_word = dmem_data_i;
                load_last = (idx_nx == LAST_MEM);
            end
            default: ;
        endcase
    end

`ifndef DUMP_DMEM_EN
    logic unused_dmem;
    assign unused_dmem = ^dmem_data_i;
`endif

    // Stream register: loads on the snap edge or each non-final transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            hdr_pc_q <= '0;
        end else begin
            if (capture) hdr_pc_q <= pc_i;
            if (load) begin
                dout_q  <= load_word;
                valid_q <= 1'b1;
                last_q  <= load_last;
            end else if (xfer) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;

endmodule

// File: tb/tb_cpu_state_dump.sv
// Directed bench for cpu_state_dump with a word scoreboard.
module tb_cpu_state_dump;

`ifdef DUMP_DMEM_EN
    localparam int TOTAL = 44;
    localparam bit HAS_MEM = 1'b1;
`else
    localparam int TOTAL = 36;
    localparam bit HAS_MEM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stall = 1'b0, branch = 1'b0, flush = 1'b0;
    logic        snap = 1'b0, rdy = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [4:0]  reg_addr;
    logic [7:0]  dmem_addr;
    logic [31:0] reg_data, dmem_data, dout;
    logic        valid, last, busy;
    logic [31:0] regs [0:31];
    logic [31:0] mem  [0:7];

    assign reg_data  = regs[reg_addr];
    assign dmem_data = mem[dmem_addr[2:0]];

    always #5 clk = ~clk;

    cpu_state_dump dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stall_i      (stall),
        .branch_i     (branch),
        .flush_i      (flush),
        .pc_i         (pc),
        .snap_i       (snap),
        .reg_addr_o   (reg_addr),
        .reg_data_i   (reg_data),
        .dmem_addr_o  (dmem_addr),
        .dmem_data_i  (dmem_data),
        .dout_o       (dout),
        .dout_valid_o (valid),
        .dout_ready_i (rdy),
        .dout_last_o  (last),
        .busy_o       (busy)
    );

    typedef struct { logic [31:0] w; logic l; } exp_t;
    exp_t        q[$];
    int          errors = 0, checks = 0;
    logic [31:0] mc = 0, ms = 0, mf = 0;
    bit          m_busy = 0, stalled_prev = 0;
    logic [31:0] held_d;
    logic        held_l;
    int          wcnt = 0, last_at = -1, n;
    logic [31:0] got [0:63];

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_stream();
        exp_t e;
        e.l = 1'b0;
        e.w = mc; q.push_back(e);
        e.w = ms; q.push_back(e);
        e.w = mf; q.push_back(e);
        e.w = pc; q.push_back(e);
        for (int i = 0; i < 32; i++) begin
            e.w = regs[i];
            e.l = !HAS_MEM && (i == 31);
            q.push_back(e);
        end
        if (HAS_MEM) begin
            for (int i = 0; i < 8; i++) begin
                e.w = mem[i];
                e.l = (i == 7);
                q.push_back(e);
            end
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, observe, update model.
    task automatic step(input logic st, input logic stl, input logic br, input logic fl,
                        input logic sn, input logic rd, input logic rs);
        bit   nb;
        exp_t e;
        @(negedge clk);
        start = st; stall = stl; branch = br; flush = fl; snap = sn; rdy = rd; rst = rs;
        #1;
        chk32("valid", {31'd0, valid}, {31'd0, m_busy});
        chk32("busy", {31'd0, busy}, {31'd0, m_busy});
        nb = m_busy;
        if (valid === 1'b1 && stalled_prev) begin
            chk32("hold_data", dout, held_d);
            chk32("hold_last", {31'd0, last}, {31'd0, held_l});
        end
        if (valid === 1'b1 && rd) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL extra_word observed=%h expected=none", dout);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk32("word", dout, e.w);
                chk32("last", {31'd0, last}, {31'd0, e.l});
                if (wcnt < 64) got[wcnt] = dout;
                if (last === 1'b1) last_at = wcnt;
                wcnt++;
                if (e.l) nb = 0;
            end
        end
        if (sn && !m_busy && !rs) begin
            push_stream();
            nb = 1;
            wcnt = 0;
            last_at = -1;
        end
        if (st && !rs) begin
            mc++;
            if (stl && !br) ms++;
            if (fl) mf++;
        end
        if (rs) begin
            nb = 0;
            q.delete();
            mc = 0; ms = 0; mf = 0;
        end
        m_busy = nb;
        stalled_prev = (valid === 1'b1) && !rd && !rs;
        held_d = dout;
        held_l = last;
    endtask

    task automatic run_idle(input bit rand_rdy, input int limit);
        n = 0;
        while (m_busy && n < limit) begin
            step(0, 0, 0, 0, 0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 0);
            n++;
        end
        checks++;
        assert (!m_busy) else begin
            errors++;
            $error("FAIL dump_timeout observed=busy expected=idle");
        end
    endtask

    initial begin
        for (int i = 0; i < 24; i++) regs[i] = 32'(i) * 32'h0101_0101;
        for (int i = 24; i < 28; i++) regs[i] = -32'(i);
        for (int i = 28; i < 32; i++) regs[i] = 32'(2 * i);
        mem[0] = 5; mem[1] = 6; mem[2] = 10; mem[3] = 18; mem[4] = 29;
        mem[5] = 32'hDEAD_0005; mem[6] = 32'hDEAD_0006; mem[7] = 32'hDEAD_0007;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk32("rst_dout", dout, 32'd0);
        chk32("rst_valid", {31'd0, valid}, 32'd0);
        chk32("rst_last", {31'd0, last}, 32'd0);
        chk32("rst_busy", {31'd0, busy}, 32'd0);
        chk32("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
        chk32("rst_dmem_addr", {24'd0, dmem_addr}, 32'd0);

        // Counting then a full dump with ready held high
        for (int i = 0; i < 10; i++)
            step(1, (i >= 2 && i <= 4), (i == 3), (i == 6 || i == 7), 0, 1, 0);
        pc = 32'h0000_1234;
        step(0, 0, 0, 0, 1, 1, 0);
        run_idle(0, 100);
        chk32("no_bubble_cycles", n, TOTAL);
        chk32("hdr_cycle", got[0], 32'd10);
        chk32("hdr_stall", got[1], 32'd2);
        chk32("hdr_flush", got[2], 32'd2);
        chk32("hdr_pc", got[3], 32'h0000_1234);
        chk32("x24", got[28], 32'hFFFF_FFE8);
        chk32("x31", got[35], 32'd62);
        if (HAS_MEM) begin
            chk32("mem0", got[36], 32'd5);
            chk32("mem1", got[37], 32'd6);
            chk32("mem2", got[38], 32'd10);
            chk32("mem3", got[39], 32'd18);
            chk32("mem4", got[40], 32'd29);
        end
        chk32("word_count", wcnt, TOTAL);
        chk32("last_position", last_at, TOTAL - 1);

        // Random backpressure
        pc = 32'hABCD_0000;
        step(0, 0, 0, 0, 1, 0, 0);
        run_idle(1, 600);
        chk32("bp_word_count", wcnt, TOTAL);
        chk32("bp_last_position", last_at, TOTAL - 1);
        chk32("bp_hdr_pc", got[3], 32'hABCD_0000);

        // Snap mid-dump is ignored, counters keep running
        pc = 32'h0000_5555;
        step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0, 1, 0);
        pc = 32'h0000_6666;
        step(1, 0, 0, 0, 1, 1, 0);
        run_idle(0, 100);
        chk32("mid_word_count", wcnt, TOTAL);
        chk32("mid_hdr_cycle", got[0], 32'd10);
        chk32("mid_hdr_pc", got[3], 32'h0000_5555);

        // Snap on the final edge is ignored; one cycle later it is accepted
        pc = 32'h0000_7777;
        step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < TOTAL - 1; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        chk32("final_edge_busy", {31'd0, m_busy}, 32'd0);
        pc = 32'h0000_8888;
        step(0, 0, 0, 0, 1, 1, 0);
        run_idle(0, 100);
        chk32("resnap_hdr_cycle", got[0], 32'd21);
        chk32("resnap_hdr_flush", got[2], 32'd12);
        chk32("resnap_hdr_pc", got[3], 32'h0000_8888);

        // Reset in the middle of a dump
        step(0, 0, 0, 0, 1, 1, 0);
        n = 0;
        while (wcnt < 20 && n < 100) begin
            step(0, 0, 0, 0, 0, 1, 0);
            n++;
        end
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk32("post_rst_valid", {31'd0, valid}, 32'd0);
        chk32("post_rst_busy", {31'd0, busy}, 32'd0);
        pc = 32'h0000_9999;
        step(0, 0, 0, 0, 1, 1, 0);
        run_idle(0, 100);
        chk32("post_rst_cycle", got[0], 32'd0);
        chk32("post_rst_stall", got[1], 32'd0);
        chk32("post_rst_flush", got[2], 32'd0);
        chk32("post_rst_pc", got[3], 32'h0000_9999);
        chk32("post_rst_count", wcnt, TOTAL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_state_dump.md
# cpu_state_dump

Synthesizable debug readout unit for the pipelined CPU: keeps cycle/stall/flush performance counters and, on request, streams a snapshot of PC, counters, register file and low data memory out over a valid/ready word interface. It sits beside the CPU top, attached to its stall/flush/branch status, to a spare register-file read port and to a spare data-memory read port. It provides in hardware the observation that the simulation bench performs via hierarchical references.

## Interface
- NUM_REGS, 32, register-file words dumped (addresses 0..NUM_REGS-1)
- NUM_DMEM, 8, data-memory words dumped (word addresses 0..NUM_DMEM-1)
- DATA_W, 32, word width of counters, PC and stream
- clk_i  in  1  single clock; everything is rising-edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  CPU running; gates all counters
- stall_i  in  1  hazard-detection stall
- branch_i  in  1  control-unit branch decode; a stall with branch_i=1 is not counted
- flush_i  in  1  pipeline flush
- pc_i  in  DATA_W  current PC
- snap_i  in  1  snapshot request, sampled each edge
- reg_addr_o  out  5  register read address
- reg_data_i  in  DATA_W  register read data, combinational from reg_addr_o
- dmem_addr_o  out  8  data-memory word address
- dmem_data_i  in  DATA_W  memory read data, combinational from dmem_addr_o
- dout_o  out  DATA_W  stream word
- dout_valid_o  out  1  stream word valid
- dout_ready_i  in  1  consumer ready
- dout_last_o  out  1  final word of the snapshot
- busy_o  out  1  snapshot in progress

## Operation
- Counters: cycle_cnt +1 on every edge with start_i=1. stall_cnt +1 on start_i & stall_i & ~branch_i. flush_cnt +1 on start_i & flush_i. All wrap modulo 2^DATA_W. Counting continues during a dump.
- FSM states: IDLE, HDR, REG, MEM.
  - IDLE→HDR on an edge with snap_i=1. That edge latches cycle_cnt, stall_cnt, flush_cnt (pre-increment values) and pc_i into header registers, and loads word 0.
  - HDR→REG after the 4th header word handshakes.
  - REG→MEM after register word NUM_REGS-1 handshakes.
  - MEM→IDLE after memory word NUM_DMEM-1 handshakes.
- Stream order: header (cycle, stall, flush, PC), then x0..x(NUM_REGS-1), then mem[0..NUM_DMEM-1]. Total 4+NUM_REGS+NUM_DMEM words (44 at defaults).
- Handshake: a transfer occurs on an edge with dout_valid_o & dout_ready_i. While valid and not ready, dout_o and dout_last_o are held stable. The next word loads on the transfer edge, so there are no bubbles when ready is held high.
- reg_addr_o and dmem_addr_o present the index of the word to be loaded at the next transfer. Read data are sampled on that edge.
- Register and memory words are live values at read time; only the header is frozen. Consistent dumps require start_i=0.
- snap_i while busy_o=1 is ignored; it is not queued.
- Reset at any point: FSM→IDLE, all counters and header registers cleared, stream aborted.

## Timing
- Reset values: dout_o=0, dout_valid_o=0, dout_last_o=0, busy_o=0, reg_addr_o=0, dmem_addr_o=0.
- Latency: snap_i sampled at edge N gives dout_valid_o=1 with the cycle word after edge N.
- Minimum dump duration, with ready held high: 44 cycles. busy_o falls on the edge the last word transfers.
- A new snap_i on that same final edge is ignored. The earliest accepted new snap is one cycle later.
- dout_last_o=1 only together with the final word.

## Configuration
- DUMP_DMEM_EN defined: MEM section present, as described above.
- DUMP_DMEM_EN undefined: REG→IDLE directly. Last word is x(NUM_REGS-1), stream is 4+NUM_REGS words. dmem_addr_o is tied 0 and dmem_data_i is unused.

## Structure
- Package cpu_dump_pkg holds:
  - state enum {IDLE, HDR, REG, MEM}
  - HDR_WORDS=4
  - header word index constants (HDR_CYCLE=0, HDR_STALL=1, HDR_FLUSH=2, HDR_PC=3)
- Sub-module perf_counter holds the three counters, with gate inputs and a capture strobe feeding the header registers.

## Test plan
- Counting: start_i=1 for 10 cycles with stall_i=1 for 3 of them (one with branch_i=1) and flush_i=1 for 2, then pulse snap_i → header words 10, 2, 2, pc_i value.
- Full dump with ready=1: regs preloaded with x24..x27=-i and x28..x31=2i, mem[0..4]=5,6,10,18,29, start_i=0 → 44 consecutive words; word 4+24 = 0xFFFFFFE8, word 4+31 = 62, words 36..40 = 5,6,10,18,29; dout_last_o only on word 43.
- Backpressure: toggle dout_ready_i randomly → dout_o stable while stalled, word sequence unchanged, no duplicated or dropped words.
- snap_i pulsed mid-dump → ignored; exactly one 44-word stream; header unchanged.
- rst_i asserted at word 20 → dout_valid_o=0 and busy_o=0 after that edge; counters read 0 in the next snapshot.
- Build without DUMP_DMEM_EN → 36 words; dout_last_o on x31 = 62.
